// File: rtl/disp_pkg.sv
// Shared segment encodings for the multiplexed 7-segment display.
// Patterns are active-low with segment a on bit 0 through segment g on bit 6.
package disp_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low segment pattern.
// Non-decimal codes show a single dash so a corrupt digit is visible.
module bcd_to_7seg
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  // digit lookup
  always_comb begin
    case (bcd)
      4'd0:    seg_n = SEG_0;
      4'd1:    seg_n = SEG_1;
      4'd2:    seg_n = SEG_2;
      4'd3:    seg_n = SEG_3;
      4'd4:    seg_n = SEG_4;
      4'd5:    seg_n = SEG_5;
      4'd6:    seg_n = SEG_6;
      4'd7:    seg_n = SEG_7;
      4'd8:    seg_n = SEG_8;
      4'd9:    seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_mux_7seg.sv
// Multiplexed N_DIG-digit 7-segment driver stepped by an asynchronous scan clock,
// with once-per-frame value latch, leading-zero blanking and anti-ghosting dead time.
module display_mux_7seg
  import disp_pkg::*;
#(
  parameter int N_DIG    = 4,
  parameter int DEAD_CYC = 500,
  parameter int SYNC_STG = 2
) (
  input  logic               reloj,
  input  logic               reset_n,
  input  logic               reloj_scan,
  input  logic [4*N_DIG-1:0] valor_bcd,
  input  logic [N_DIG-1:0]   dp_mask,
  input  logic               blank_lz,
  output logic [N_DIG-1:0]   an_n,
  output logic [6:0]         seg_n,
  output logic               dp_n,
  output logic               frame_start
);

  localparam int IW = $clog2(N_DIG);
  localparam int CW = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
  localparam logic [IW-1:0]    IDX_LAST  = IW'(N_DIG - 1);
  localparam logic [CW-1:0]    DEAD_LOAD = CW'(DEAD_CYC);
  localparam logic [N_DIG-1:0] ONE_HOT0  = N_DIG'(1'b1);

  logic [SYNC_STG-1:0] sync_r;
  logic                hist_r;
  logic                tick_s;

  logic [IW-1:0]       idx_r, idx_wrap_s, idx_nxt_s;
  logic                run_r, run_nxt_s;
  logic [CW-1:0]       cnt_r, cnt_nxt_s;
  logic [4*N_DIG-1:0]  latch_r, latch_nxt_s;
  logic [N_DIG-1:0]    latch_dp_r, latch_dp_nxt_s;
  logic                latch_blk_r, latch_blk_nxt_s;
  logic                frame_nxt_s;

  logic [N_DIG-1:0]    lz_s;
  logic                blank_s;
  logic                show_s;
  logic [3:0]          digit_s;
  logic [6:0]          dec_seg_s;

  // scan clock synchroniser and rising-edge history
  always_ff @(posedge reloj) begin
    if (!reset_n) begin
      sync_r <= {SYNC_STG{1'b0}};
      hist_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STG-2:0], reloj_scan};
      hist_r <= sync_r[SYNC_STG-1];
    end
  end

  assign tick_s = sync_r[SYNC_STG-1] & ~hist_r;

  // next scan state; outputs are registered from these so the anode moves on the tick cycle
  always_comb begin
    idx_wrap_s      = (idx_r == IDX_LAST) ? {IW{1'b0}} : idx_r + IW'(1'b1);
    idx_nxt_s       = idx_r;
    run_nxt_s       = run_r;
    cnt_nxt_s       = cnt_r;
    latch_nxt_s     = latch_r;
    latch_dp_nxt_s  = latch_dp_r;
    latch_blk_nxt_s = latch_blk_r;
    frame_nxt_s     = 1'b0;
    if (tick_s) begin
      run_nxt_s = 1'b1;
      idx_nxt_s = idx_wrap_s;
      cnt_nxt_s = DEAD_LOAD;
      if (idx_wrap_s == {IW{1'b0}}) begin
        latch_nxt_s     = valor_bcd;
        latch_dp_nxt_s  = dp_mask;
        latch_blk_nxt_s = blank_lz;
        frame_nxt_s     = 1'b1;
      end else begin
        frame_nxt_s     = 1'b0;
      end
    end else if (cnt_r != {CW{1'b0}}) begin
      cnt_nxt_s = cnt_r - CW'(1'b1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // scan state registers
  always_ff @(posedge reloj) begin
    if (!reset_n) begin
      idx_r       <= {IW{1'b0}};
      run_r       <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      latch_r     <= {(4*N_DIG){1'b0}};
      latch_dp_r  <= {N_DIG{1'b0}};
      latch_blk_r <= 1'b0;
    end else begin
      idx_r       <= idx_nxt_s;
      run_r       <= run_nxt_s;
      cnt_r       <= cnt_nxt_s;
      latch_r     <= latch_nxt_s;
      latch_dp_r  <= latch_dp_nxt_s;
      latch_blk_r <= latch_blk_nxt_s;
    end
  end

  // lz_s[k]: latched digits N_DIG-1 down to k are all zero
  always_comb begin
    lz_s = {N_DIG{1'b0}};
    lz_s[N_DIG-1] = (latch_nxt_s[4*N_DIG-1 -: 4] == 4'h0);
    for (int k = N_DIG - 2; k >= 0; k--) begin
      lz_s[k] = lz_s[k+1] & (latch_nxt_s[4*k +: 4] == 4'h0);
    end
  end

  assign blank_s = latch_blk_nxt_s && (idx_nxt_s != {IW{1'b0}}) && lz_s[idx_nxt_s];
  assign show_s  = run_nxt_s && (cnt_nxt_s == {CW{1'b0}});
  assign digit_s = latch_nxt_s[{idx_nxt_s, 2'b00} +: 4];

  bcd_to_7seg u_dec (
    .bcd   (digit_s),
    .seg_n (dec_seg_s)
  );

  // registered display drive
  always_ff @(posedge reloj) begin
    if (!reset_n) begin
      an_n        <= {N_DIG{1'b1}};
      seg_n       <= SEG_OFF;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_nxt_s;
      if (show_s) begin
        an_n  <= ~(ONE_HOT0 << idx_nxt_s);
        seg_n <= blank_s ? SEG_OFF : dec_seg_s;
        dp_n  <= ~latch_dp_nxt_s[idx_nxt_s];
      end else begin
        an_n  <= {N_DIG{1'b1}};
        seg_n <= SEG_OFF;
        dp_n  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_mux_7seg.sv
// Scoreboard bench: two instances (no dead time, 500-cycle dead time) share stimulus;
// a spec-level model predicts every output change and frame pulse with its cycle.
module tb_display_mux_7seg;

  localparam int SYNC = 2;
  localparam int DEAD = 500;
  localparam logic [11:0] DARK = {4'hF, 7'h7F, 1'b1};

  logic clk = 1'b0;
  logic rst_n, scan, blk;
  logic [15:0] valor;
  logic [3:0]  dpm;
  logic [3:0]  an0, an5;
  logic [6:0]  seg0, seg5;
  logic        dp0, dp5, fs0, fs5;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [11:0] val;
  } ev_t;

  ev_t q0[$];
  ev_t q5[$];
  int  fq0[$];
  int  fq5[$];
  logic [11:0] last0, last5, prev0, prev5;
  int pend5;

  logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int          m_idx;
  logic [15:0] m_latch;
  logic [3:0]  m_dp;
  logic        m_blk;

  display_mux_7seg #(.N_DIG(4), .DEAD_CYC(0), .SYNC_STG(SYNC)) dut0 (
    .reloj(clk), .reset_n(rst_n), .reloj_scan(scan), .valor_bcd(valor),
    .dp_mask(dpm), .blank_lz(blk), .an_n(an0), .seg_n(seg0), .dp_n(dp0),
    .frame_start(fs0)
  );

  display_mux_7seg #(.N_DIG(4), .DEAD_CYC(DEAD), .SYNC_STG(SYNC)) dut5 (
    .reloj(clk), .reset_n(rst_n), .reloj_scan(scan), .valor_bcd(valor),
    .dp_mask(dpm), .blank_lz(blk), .an_n(an5), .seg_n(seg5), .dp_n(dp5),
    .frame_start(fs5)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got_c, input int exp_c,
                       input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got_c != exp_c || got !== exp) begin
      errors++;
      $display("FAIL %s: got cycle %0d value %h, expected cycle %0d value %h",
               name, got_c, got, exp_c, exp);
    end
  endtask

  // Display content the spec says digit m_idx should show from the current latch.
  function automatic logic [11:0] lit_val();
    logic [3:0] d;
    logic [6:0] s;
    d = 4'((m_latch >> (4 * m_idx)) & 16'hF);
    if (m_blk && m_idx != 0 && (m_latch >> (4 * m_idx)) == 16'h0) s = 7'h7F;
    else if (d < 4'd10) s = seg_tbl[d];
    else s = 7'h3F;
    return {~(4'b0001 << m_idx), s, ~m_dp[m_idx]};
  endfunction

  task automatic push_ev(input bit slow, input int c, input logic [11:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    if (!slow) begin
      if (v !== last0) begin q0.push_back(e); last0 = v; end
    end else begin
      if (v !== last5) begin q5.push_back(e); last5 = v; end
    end
  endtask

  task automatic model_tick(input int t);
    m_idx = (m_idx == 3) ? 0 : m_idx + 1;
    if (m_idx == 0) begin
      m_latch = valor; m_dp = dpm; m_blk = blk;
      fq0.push_back(t); fq5.push_back(t);
    end
    push_ev(1'b0, t, lit_val());
    if (pend5 >= t) begin void'(q5.pop_back()); last5 = DARK; end
    push_ev(1'b1, t, DARK);
    push_ev(1'b1, t + DEAD, lit_val());
    pend5 = t + DEAD;
  endtask

  task automatic model_reset(input int r);
    m_idx = 0; m_latch = 16'h0; m_dp = 4'h0; m_blk = 1'b0;
    push_ev(1'b0, r, DARK);
    if (pend5 >= r) begin void'(q5.pop_back()); last5 = DARK; end
    push_ev(1'b1, r, DARK);
    pend5 = -1;
  endtask

  task automatic do_tick(input int gap);
    int p;
    @(negedge clk);
    p = cyc;
    scan = 1'b1;
    model_tick(p + SYNC + 1);
    repeat (6) @(negedge clk);
    scan = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset(cyc + 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // monitor: every output change or frame pulse must match the head of its queue
  always @(negedge clk) begin
    ev_t e;
    int  f;
    if ({an0, seg0, dp0} !== prev0) begin
      if (q0.size() == 0) check("out0_unexpected", cyc, -1, {an0, seg0, dp0}, prev0);
      else begin e = q0.pop_front(); check("out0", cyc, e.cyc, {an0, seg0, dp0}, e.val); end
      prev0 = {an0, seg0, dp0};
    end
    if ({an5, seg5, dp5} !== prev5) begin
      if (q5.size() == 0) check("out5_unexpected", cyc, -1, {an5, seg5, dp5}, prev5);
      else begin e = q5.pop_front(); check("out5", cyc, e.cyc, {an5, seg5, dp5}, e.val); end
      prev5 = {an5, seg5, dp5};
    end
    if (fs0 !== 1'b0) begin
      f = (fq0.size() == 0) ? -1 : fq0.pop_front();
      check("frame0", cyc, f, {11'd0, fs0}, 12'h001);
    end
    if (fs5 !== 1'b0) begin
      f = (fq5.size() == 0) ? -1 : fq5.pop_front();
      check("frame5", cyc, f, {11'd0, fs5}, 12'h001);
    end
  end

  initial begin
    rst_n = 1'b0; scan = 1'b0; valor = 16'h1234; dpm = 4'h0; blk = 1'b0;
    m_idx = 0; m_latch = 16'h0; m_dp = 4'h0; m_blk = 1'b0;
    last0 = DARK; last5 = DARK; prev0 = DARK; prev5 = DARK; pend5 = -1;

    repeat (5) begin
      @(negedge clk);
      check("rst_out0", 0, 0, {an0, seg0, dp0}, DARK);
      check("rst_out5", 0, 0, {an5, seg5, dp5}, DARK);
      check("rst_fs", 0, 0, {10'd0, fs0, fs5}, 12'h000);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1234 shown as 4,3,2,1 once the first frame latches
    for (int i = 0; i < 8; i++) do_tick(600);

    valor = 16'h0070; blk = 1'b1;
    for (int i = 0; i < 4; i++) do_tick(600);

    valor = 16'h00A5; blk = 1'b0; dpm = 4'b0100;
    for (int i = 0; i < 4; i++) do_tick(600);

    // mid-frame change: old value must persist until the wrap
    while (m_idx != 2) do_tick(600);
    valor = 16'h9806; dpm = 4'b1001;
    for (int i = 0; i < 4; i++) do_tick(600);

    while (m_idx != 3) do_tick(600);
    do_reset();
    repeat (5) @(negedge clk);
    for (int i = 0; i < 5; i++) do_tick(550);

    for (int i = 0; i < 36; i++) begin
      if ($urandom_range(0, 2) == 0) do_tick($urandom_range(10, 480));
      else do_tick($urandom_range(500, 700));
      if ($urandom_range(0, 1) == 1) begin
        valor = 16'($urandom);
        if ($urandom_range(0, 1) == 1) valor = valor & 16'h00FF;
        dpm = 4'($urandom);
        blk = 1'($urandom);
      end
      if (i == 20) do_reset();
    end

    repeat (DEAD + 100) @(negedge clk);
    check("drain_out0", q0.size(), 0, 12'h0, 12'h0);
    check("drain_out5", q5.size(), 0, 12'h0, 12'h0);
    check("drain_frame", fq0.size() + fq5.size(), 0, 12'h0, 12'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
